// File: rtl/axis_packet_arbiter_if.sv
// Stream bundle for axis_packet_arbiter: NUM_PORTS slave streams in, one merged master stream out.
// m_axis_tdest exists only when AXIS_ARB_TDEST_EN is defined.
interface axis_packet_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [NUM_PORTS-1:0]            s_axis_tlast;

  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic [KEEP_WIDTH-1:0]           m_axis_tkeep;
  logic                            m_axis_tlast;
`ifdef AXIS_ARB_TDEST_EN
  logic [$clog2(NUM_PORTS)-1:0]    m_axis_tdest;
`endif

  modport master (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
`ifdef AXIS_ARB_TDEST_EN
    , output m_axis_tdest
`endif
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
`ifdef AXIS_ARB_TDEST_EN
    , input m_axis_tdest
`endif
  );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS AXI4-Stream sources behind a 2-entry output buffer.
// Optional macro AXIS_ARB_TDEST_EN adds m_axis_tdest carrying the grant index of every beat.
module axis_packet_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  aclk,
  input  logic                  areset,
  axis_packet_arbiter_if.master bus,
  output logic                  busy
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int GW = $clog2(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] ONE       = NUM_PORTS'(1);
  localparam logic [GW-1:0]        LAST_PORT = GW'(NUM_PORTS - 1);
`ifdef AXIS_ARB_TDEST_EN
  localparam int BW = DATA_WIDTH + KW + 1 + GW;
`else
  localparam int BW = DATA_WIDTH + KW + 1;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state;
  logic [GW-1:0]          grant;
  logic [GW-1:0]          rr_ptr;
  logic [GW-1:0]          pick;
  logic [NUM_PORTS-1:0]   tready_q;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [KW-1:0]          in_keep;
  logic                   in_last;
  logic [BW-1:0]          in_beat;
  logic [BW-1:0]          out_beat;
  logic [BW-1:0]          skid_beat;
  logic                   out_valid;
  logic                   skid_valid;
  logic                   push;
  logic                   pop;
  logic [1:0]             count_next;
  logic                   room_next;

  // Lowest valid index wins first; a valid index at or after rr_ptr then overrides it (wrap-around search).
  always_comb begin
    pick = '0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (bus.s_axis_tvalid[j]) pick = GW'(j);
    end
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (bus.s_axis_tvalid[j] && (GW'(j) >= rr_ptr)) pick = GW'(j);
    end
  end

  always_comb begin
    in_valid = 1'b0;
    in_ready = 1'b0;
    in_data  = '0;
    in_keep  = '0;
    in_last  = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (grant == GW'(j)) begin
        in_valid = bus.s_axis_tvalid[j];
        in_ready = tready_q[j];
        in_data  = bus.s_axis_tdata[j*DATA_WIDTH +: DATA_WIDTH];
        in_keep  = bus.s_axis_tkeep[j*KW +: KW];
        in_last  = bus.s_axis_tlast[j];
      end
    end
  end

  assign push       = in_valid & in_ready;
  assign pop        = out_valid & bus.m_axis_tready;
  assign count_next = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, push} - {1'b0, pop};
  assign room_next  = (count_next != 2'd2);

  // Ready is computed from next cycle's occupancy so it can be registered without losing throughput.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      tready_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.s_axis_tvalid) begin
            grant    <= pick;
            state    <= BUSY;
            tready_q <= room_next ? (ONE << pick) : '0;
          end else begin
            tready_q <= '0;
          end
        end
        BUSY: begin
          if (push && in_last) begin
            state    <= IDLE;
            rr_ptr   <= (grant == LAST_PORT) ? '0 : grant + 1'b1;
            tready_q <= '0;
          end else begin
            tready_q <= room_next ? (ONE << grant) : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register plus skid entry; the skid only fills when a beat arrives while the output is stalled.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_beat   <= '0;
      out_valid  <= 1'b0;
      skid_beat  <= '0;
      skid_valid <= 1'b0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_beat  <= skid_beat;
        out_valid <= 1'b1;
      end else begin
        out_valid <= push;
        if (push) out_beat <= in_beat;
      end
      if (skid_valid && push) skid_beat <= in_beat;
      skid_valid <= skid_valid && push;
    end else if (push) begin
      skid_beat  <= in_beat;
      skid_valid <= 1'b1;
    end
  end

`ifdef AXIS_ARB_TDEST_EN
  assign in_beat          = {grant, in_last, in_keep, in_data};
  assign bus.m_axis_tdest = out_beat[BW-1 -: GW];
`else
  assign in_beat          = {in_last, in_keep, in_data};
`endif

  assign bus.s_axis_tready = tready_q;
  assign bus.m_axis_tvalid = out_valid;
  assign bus.m_axis_tdata  = out_beat[DATA_WIDTH-1:0];
  assign bus.m_axis_tkeep  = out_beat[DATA_WIDTH +: KW];
  assign bus.m_axis_tlast  = out_beat[DATA_WIDTH + KW];
  assign busy              = (state == BUSY);
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: per-scenario tasks against a packet-level round-robin reference model.
// Build with AXIS_ARB_TDEST_EN defined to also cover m_axis_tdest.
module tb_axis_packet_arbiter;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = 8;

  typedef struct packed {
    logic [3:0]    port;
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic aclk = 1'b0;
  logic areset;
  logic busy;

  axis_packet_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

  axis_packet_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus.master),
    .busy   (busy)
  );

  always #5 aclk = ~aclk;

  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  beat_t    src_q[NP][$];
  beat_t    mdl_q[NP][$];
  beat_t    exp_q[$];
  beat_t    out_q[$];
  int       mdl_ptr = 0;
  logic [NP-1:0] src_en = '1;
  int       ready_mode = 0;
  int       acc_cnt[NP];
  int       last_acc_cyc = 0;
  int       last_out_cyc = 0;

  task automatic add_packet(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.port = 4'(p);
      b.last = (i == len - 1);
      b.keep = 8'($urandom);
      b.data = {4'(p), 28'($urandom), 32'($urandom)};
      src_q[p].push_back(b);
      mdl_q[p].push_back(b);
    end
  endtask

  // Reference: whole packets leave in round-robin order starting at the pointer, never interleaved.
  task automatic model_arbitrate();
    int    found;
    int    q;
    beat_t b;
    forever begin
      found = -1;
      for (int k = 0; k < NP; k++) begin
        q = (mdl_ptr + k) % NP;
        if (found < 0 && mdl_q[q].size() > 0) found = q;
      end
      if (found < 0) break;
      do begin
        b = mdl_q[found].pop_front();
        exp_q.push_back(b);
      end while (!b.last);
      mdl_ptr = (found + 1) % NP;
    end
  endtask

  // One clock: drive at the falling edge, then record the handshakes the next rising edge will complete.
  task automatic cycle();
    logic [NP-1:0] tv;
    beat_t         ob;
    @(negedge aclk);
    tv = '0;
    for (int p = 0; p < NP; p++) begin
      if (src_en[p] && src_q[p].size() > 0) begin
        tv[p] = 1'b1;
        bus.s_axis_tdata[p*DW +: DW] = src_q[p][0].data;
        bus.s_axis_tkeep[p*KW +: KW] = src_q[p][0].keep;
        bus.s_axis_tlast[p]          = src_q[p][0].last;
      end
    end
    bus.s_axis_tvalid = tv;
    case (ready_mode)
      0:       bus.m_axis_tready = 1'b1;
      1:       bus.m_axis_tready = (cyc % 2 == 0);
      default: bus.m_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
    if (!areset) begin
      for (int p = 0; p < NP; p++) begin
        if (tv[p] && bus.s_axis_tready[p]) begin
          src_q[p].delete(0);
          acc_cnt[p]++;
          last_acc_cyc = cyc;
        end
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        ob.data = bus.m_axis_tdata;
        ob.keep = bus.m_axis_tkeep;
        ob.last = bus.m_axis_tlast;
`ifdef AXIS_ARB_TDEST_EN
        ob.port = 4'(bus.m_axis_tdest);
`else
        ob.port = bus.m_axis_tdata[63:60];
`endif
        out_q.push_back(ob);
        last_out_cyc = cyc;
      end
    end
    cyc++;
  endtask

  function automatic bit sources_empty();
    for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_traffic(input int budget);
    int n = 0;
    while (n < budget && !(sources_empty() && out_q.size() >= exp_q.size())) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout got=%0d beats need=%0d", out_q.size(), exp_q.size());
    end
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    bus.s_axis_tvalid = '1;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    total++;
    if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_mvalid got=%b exp=0", bus.m_axis_tvalid); end
    total++;
    if (bus.s_axis_tready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_sready got=%b exp=0000", bus.s_axis_tready); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++;
    if ({bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_payload got=%h/%h/%b exp=0", bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast);
    end
    bus.s_axis_tvalid = '0;
    areset = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic test_round_robin();
    beat_t g;
    logic [3:0] got_port;
    ready_mode = 0;
    for (int r = 0; r < 3; r++) for (int p = 0; p < NP; p++) add_packet(p, 3);
    model_arbitrate();
    run_traffic(600);
    total++;
    if (out_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL rr_count got=%0d exp=%0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < out_q.size()) ? out_q[i] : '0;
      total++;
      if (g !== exp_q[i]) begin bad++; $display("[TB] FAIL rr_beat%0d got=%h exp=%h", i, g, exp_q[i]); end
    end
    for (int k = 0; k < 12; k++) begin
      got_port = (3*k < out_q.size()) ? out_q[3*k].data[63:60] : 4'hf;
      total++;
      if (got_port !== 4'(k % 4)) begin bad++; $display("[TB] FAIL rr_order pkt%0d got=%0d exp=%0d", k, got_port, k % 4); end
    end
    for (int i = 0; i < out_q.size(); i++) begin
      total++;
      if (out_q[i].last !== (i % 3 == 2)) begin bad++; $display("[TB] FAIL rr_tlast beat%0d got=%b exp=%b", i, out_q[i].last, (i % 3 == 2)); end
    end
    exp_q.delete();
    out_q.delete();
  endtask

  task automatic test_priority_skip();
    beat_t g;
    add_packet(1, 1);
    model_arbitrate();
    run_traffic(100);
    exp_q.delete();
    out_q.delete();
    add_packet(1, 2);
    add_packet(3, 2);
    model_arbitrate();
    run_traffic(100);
    total++;
    if (out_q.size() !== 4) begin bad++; $display("[TB] FAIL skip_count got=%0d exp=4", out_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < out_q.size()) ? out_q[i] : '0;
      total++;
      if (g !== exp_q[i]) begin bad++; $display("[TB] FAIL skip_beat%0d got=%h exp=%h", i, g, exp_q[i]); end
    end
    g = (out_q.size() > 0) ? out_q[0] : '0;
    total++;
    if (g.data[63:60] !== 4'd3) begin bad++; $display("[TB] FAIL skip_first got=%0d exp=3", g.data[63:60]); end
    g = (out_q.size() > 2) ? out_q[2] : '0;
    total++;
    if (g.data[63:60] !== 4'd1) begin bad++; $display("[TB] FAIL skip_second got=%0d exp=1", g.data[63:60]); end
    exp_q.delete();
    out_q.delete();
  endtask

  task automatic test_backpressure();
    beat_t g;
    beat_t held;
    logic  hold;
    int    n;
    int    stable_checks;
    ready_mode = 1;
    hold = 1'b0;
    held = '0;
    n = 0;
    stable_checks = 0;
    add_packet(2, 8);
    model_arbitrate();
    while (n < 200 && !(sources_empty() && out_q.size() >= exp_q.size())) begin
      cycle();
      n++;
      if (hold) begin
        stable_checks++;
        total++;
        if (!bus.m_axis_tvalid || {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata} !== {held.last, held.keep, held.data}) begin
          bad++;
          $display("[TB] FAIL bp_stable got=%b/%h exp=1/%h", bus.m_axis_tvalid, bus.m_axis_tdata, held.data);
        end
      end
      hold = bus.m_axis_tvalid && !bus.m_axis_tready;
      held.data = bus.m_axis_tdata;
      held.keep = bus.m_axis_tkeep;
      held.last = bus.m_axis_tlast;
    end
    total++;
    if (n >= 200 || stable_checks == 0) begin bad++; $display("[TB] FAIL bp_progress got=%0d cycles/%0d holds exp=done", n, stable_checks); end
    repeat (3) cycle();
    total++;
    if (out_q.size() !== 8) begin bad++; $display("[TB] FAIL bp_count got=%0d exp=8", out_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < out_q.size()) ? out_q[i] : '0;
      total++;
      if (g !== exp_q[i]) begin bad++; $display("[TB] FAIL bp_beat%0d got=%h exp=%h", i, g, exp_q[i]); end
    end
    ready_mode = 0;
    exp_q.delete();
    out_q.delete();
  endtask

  task automatic test_single_beat();
    beat_t g;
    int    n;
    n = 0;
    ready_mode = 0;
    add_packet(2, 1);
    model_arbitrate();
    while (n < 50 && out_q.size() == 0) begin
      cycle();
      n++;
    end
    total++;
    if (out_q.size() == 0) begin bad++; $display("[TB] FAIL single_seen got=0 beats exp=1"); end
    total++;
    if (last_out_cyc - last_acc_cyc !== 1) begin bad++; $display("[TB] FAIL single_latency got=%0d exp=1", last_out_cyc - last_acc_cyc); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_idle got=%b exp=0", busy); end
    g = (out_q.size() > 0) ? out_q[0] : '0;
    total++;
    if (g !== exp_q[0]) begin bad++; $display("[TB] FAIL single_beat got=%h exp=%h", g, exp_q[0]); end
    repeat (3) cycle();
    exp_q.delete();
    out_q.delete();
  endtask

  task automatic test_stall();
    beat_t g;
    int    base;
    int    n;
    n = 0;
    base = acc_cnt[0];
    add_packet(0, 6);
    model_arbitrate();
    while (n < 50 && acc_cnt[0] - base < 2) begin
      cycle();
      n++;
    end
    src_en[0] = 1'b0;
    add_packet(1, 2);
    add_packet(3, 2);
    model_arbitrate();
    for (int s = 0; s < 5; s++) begin
      cycle();
      total++;
      if ((bus.s_axis_tready & 4'b1110) !== 4'b0000 || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stall_hold%0d got=%b/%b exp=xxx0/1", s, bus.s_axis_tready, busy);
      end
    end
    src_en[0] = 1'b1;
    run_traffic(300);
    total++;
    if (out_q.size() !== 10) begin bad++; $display("[TB] FAIL stall_count got=%0d exp=10", out_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < out_q.size()) ? out_q[i] : '0;
      total++;
      if (g !== exp_q[i]) begin bad++; $display("[TB] FAIL stall_beat%0d got=%h exp=%h", i, g, exp_q[i]); end
    end
    g = (out_q.size() > 6) ? out_q[6] : '0;
    total++;
    if (g.data[63:60] !== 4'd1) begin bad++; $display("[TB] FAIL stall_next got=%0d exp=1", g.data[63:60]); end
    exp_q.delete();
    out_q.delete();
  endtask

  task automatic test_random();
    beat_t g;
    int    added;
    ready_mode = 2;
    for (int r = 0; r < 4; r++) begin
      added = 0;
      for (int p = 0; p < NP; p++) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          add_packet(p, $urandom_range(1, 5));
          added++;
        end
      end
      if (added == 0) add_packet($urandom_range(0, NP - 1), $urandom_range(1, 5));
      model_arbitrate();
      run_traffic(1000);
      total++;
      if (out_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL rand%0d_count got=%0d exp=%0d", r, out_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        g = (i < out_q.size()) ? out_q[i] : '0;
        total++;
        if (g !== exp_q[i]) begin bad++; $display("[TB] FAIL rand%0d_beat%0d got=%h exp=%h", r, i, g, exp_q[i]); end
      end
      exp_q.delete();
      out_q.delete();
    end
    ready_mode = 0;
  endtask

  task automatic test_mid_reset();
    beat_t g;
    int    base;
    int    n;
    n = 0;
    ready_mode = 0;
    add_packet(1, 1);
    model_arbitrate();
    run_traffic(100);
    exp_q.delete();
    out_q.delete();
    base = acc_cnt[2];
    add_packet(2, 4);
    while (n < 50 && acc_cnt[2] - base < 2) begin
      cycle();
      n++;
    end
    @(posedge aclk);
    #1;
    total++;
    if (bus.m_axis_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL mrst_pre got=%b exp=1", bus.m_axis_tvalid); end
    #1 areset = 1'b1;
    #1;
    total++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mrst_now got=%b/%b/%b exp=0/0000/0", bus.m_axis_tvalid, bus.s_axis_tready, busy);
    end
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      mdl_q[p].delete();
    end
    exp_q.delete();
    out_q.delete();
    mdl_ptr = 0;
    bus.s_axis_tvalid = '0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    add_packet(2, 1);
    add_packet(0, 1);
    model_arbitrate();
    run_traffic(100);
    g = (out_q.size() > 0) ? out_q[0] : '0;
    total++;
    if (g.data[63:60] !== 4'd0) begin bad++; $display("[TB] FAIL mrst_grant got=%0d exp=0", g.data[63:60]); end
    total++;
    if (out_q.size() !== 2) begin bad++; $display("[TB] FAIL mrst_count got=%0d exp=2", out_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < out_q.size()) ? out_q[i] : '0;
      total++;
      if (g !== exp_q[i]) begin bad++; $display("[TB] FAIL mrst_beat%0d got=%h exp=%h", i, g, exp_q[i]); end
    end
    exp_q.delete();
    out_q.delete();
  endtask

  initial begin
    for (int p = 0; p < NP; p++) acc_cnt[p] = 0;
    test_reset();
    test_round_robin();
    test_priority_skip();
    test_backpressure();
    test_single_beat();
    test_stall();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
